// File: rtl/calc_pkg.sv
// Shared calculator definitions: serializer FSM states, default digit geometry and special digit codes.
package calc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SKIP  = 2'd1,
        SHIFT = 2'd2
    } state_t;

    localparam int DIGIT_WIDTH = 4;
    localparam int DIGIT_COUNT = 4;

    localparam logic [3:0] ZERO_DIGIT = 4'h0;
    // Blank key code, shared with the keypad input unit.
    localparam logic [3:0] BLANK_KEY  = 4'hE;

endpackage

// File: rtl/digit_serializer.sv
// Serializes a packed COUNT-digit word one digit per handshake, most-significant digit first.
// Define DIGIT_SERIALIZER_BLANK_ZEROS_EN to suppress leading zero digits (at least one digit is always sent).
module digit_serializer
    import calc_pkg::*;
#(
    parameter int COUNT = DIGIT_COUNT,
    parameter int WIDTH = DIGIT_WIDTH
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [COUNT*WIDTH-1:0] in,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [WIDTH-1:0]       out,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   out_last,
    output logic                   busy
);

    localparam int CW = $clog2(COUNT + 1);

    state_t                 state, state_nxt;
    logic [COUNT*WIDTH-1:0] sreg, sreg_nxt;
    logic [CW-1:0]          cnt, cnt_nxt;
    logic [WIDTH-1:0]       top;

    assign top = sreg[COUNT*WIDTH-1 -: WIDTH];

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            sreg  <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            sreg  <= sreg_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        sreg_nxt  = sreg;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    sreg_nxt  = in;
                    cnt_nxt   = CW'(COUNT);
`ifdef DIGIT_SERIALIZER_BLANK_ZEROS_EN
                    state_nxt = SKIP;
`else
                    state_nxt = SHIFT;
`endif
                end
            end
`ifdef DIGIT_SERIALIZER_BLANK_ZEROS_EN
            SKIP: begin
                // The cnt>1 guard keeps the final digit even when the whole word is zero.
                if (top == WIDTH'(ZERO_DIGIT) && cnt > CW'(1)) begin
                    sreg_nxt = sreg << WIDTH;
                    cnt_nxt  = cnt - CW'(1);
                end else begin
                    state_nxt = SHIFT;
                end
            end
`endif
            SHIFT: begin
                if (out_ready) begin
                    if (cnt == CW'(1)) begin
                        state_nxt = IDLE;
                        sreg_nxt  = '0;
                        cnt_nxt   = '0;
                    end else begin
                        sreg_nxt = sreg << WIDTH;
                        cnt_nxt  = cnt - CW'(1);
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // All outputs decode registered state only.
    assign in_ready  = (state == IDLE);
    assign busy      = (state != IDLE);
    assign out_valid = (state == SHIFT);
    assign out       = top;
    assign out_last  = (state == SHIFT) && (cnt == CW'(1));

endmodule

// File: tb/tb_digit_serializer.sv
// Randomized and directed bench for digit_serializer with a queue-based reference of the expected digit stream.
module tb_digit_serializer;

`ifdef DIGIT_SERIALIZER_BLANK_ZEROS_EN
    localparam bit FEAT = 1'b1;
`else
    localparam bit FEAT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] in = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  out;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        out_last;
    logic        busy;

    digit_serializer #(.COUNT(4), .WIDTH(4)) dut (
        .clk(clk), .reset(reset), .in(in), .in_valid(in_valid), .in_ready(in_ready),
        .out(out), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last), .busy(busy)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference: digits still owed for the current word, and the cycle from which they become visible.
    logic [3:0] q[$];
    bit         exp_busy = 1'b0;
    int         cyc = 0;
    int         valid_from = 0;
    bit         started = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            q.delete();
            exp_busy = 1'b0;
        end else if (exp_busy) begin
            if (cyc >= valid_from && out_ready) begin
                void'(q.pop_front());
                if (q.size() == 0) exp_busy = 1'b0;
            end
        end else if (in_valid) begin
            int z = 0;
            for (int i = 3; i >= 0; i--) q.push_back(in[i*4 +: 4]);
            if (FEAT) begin
                while (q.size() > 1 && q[0] == 4'h0) begin
                    void'(q.pop_front());
                    z++;
                end
                valid_from = cyc + 2 + z;
            end else begin
                valid_from = cyc + 1;
            end
            exp_busy = 1'b1;
        end
        cyc++;
    end

    always @(negedge clk) begin
        if (started) begin
            bit exp_valid;
            exp_valid = exp_busy && (cyc >= valid_from);
            chk("out_valid", out_valid, exp_valid);
            chk("busy", busy, exp_busy);
            chk("in_ready", in_ready, !exp_busy);
            if (exp_valid) begin
                chk("out", out, q[0]);
                chk("out_last", out_last, q.size() == 1);
            end else if (!exp_busy) begin
                chk("idle_out", out, 4'h0);
                chk("idle_out_last", out_last, 1'b0);
            end
        end
    end

    // Digits actually transferred, for the directed literal checks.
    logic [3:0] got[$];
    always @(posedge clk) begin
        if (!reset && out_valid && out_ready) got.push_back(out);
    end

    task automatic send(input logic [15:0] w);
        int n = 0;
        while (!in_ready && n < 200) begin
            @(posedge clk); #1; n++;
        end
        chk("send_ready_timeout", n < 200, 1'b1);
        in = w;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic first_valid(input string name, input int expd);
        int d = 1;
        while (!out_valid && d < 50) begin
            @(posedge clk); #1; d++;
        end
        chk(name, d, expd);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 200) begin
            @(posedge clk); #1; n++;
        end
        chk("idle_timeout", n < 200, 1'b1);
    endtask

    task automatic check_stream(input string name, input logic [3:0] e[$]);
        chk({name, "_len"}, got.size(), e.size());
        for (int i = 0; i < e.size() && i < got.size(); i++) chk(name, got[i], e[i]);
        got.delete();
    endtask

    function automatic logic [15:0] rand_word();
        logic [15:0] w;
        for (int i = 0; i < 4; i++)
            w[i*4 +: 4] = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
        return w;
    endfunction

    initial begin
        logic [3:0] e[$];
        int n;

        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        started = 1'b1;
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_out", out, 4'h0);
        chk("rst_out_last", out_last, 1'b0);

        // Basic word, consumer always ready.
        out_ready = 1'b1;
        got.delete();
        send(16'h1234);
        first_valid("lat_1234", FEAT ? 2 : 1);
        wait_idle();
        e = '{4'h1, 4'h2, 4'h3, 4'h4};
        check_stream("s_1234", e);

        // Stall while digit 6 is presented.
        out_ready = 1'b0;
        send(16'h5678);
        first_valid("lat_5678", FEAT ? 2 : 1);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            chk("stall_out", out, 4'h6);
            chk("stall_valid", out_valid, 1'b1);
        end
        out_ready = 1'b1;
        wait_idle();
        e = '{4'h5, 4'h6, 4'h7, 4'h8};
        check_stream("s_5678", e);

        // A second word offered while busy is ignored.
        send(16'h1234);
        in = 16'h9999;
        in_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        in_valid = 1'b0;
        wait_idle();
        e = '{4'h1, 4'h2, 4'h3, 4'h4};
        check_stream("s_ignore", e);

        // Reset after the second digit is accepted.
        send(16'hABCD);
        n = 0;
        while (got.size() < 2 && n < 50) begin
            @(posedge clk); #1; n++;
        end
        chk("abcd_timeout", n < 50, 1'b1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("mid_rst_valid", out_valid, 1'b0);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_ready", in_ready, 1'b1);
        e = '{4'hA, 4'hB};
        check_stream("s_abcd", e);
        send(16'h0001);
        wait_idle();
        if (FEAT) e = '{4'h1};
        else e = '{4'h0, 4'h0, 4'h0, 4'h1};
        check_stream("s_0001", e);

        // Leading-zero handling.
        send(16'h0056);
        first_valid("lat_0056", FEAT ? 4 : 1);
        wait_idle();
        if (FEAT) e = '{4'h5, 4'h6};
        else e = '{4'h0, 4'h0, 4'h5, 4'h6};
        check_stream("s_0056", e);

        send(16'h0000);
        first_valid("lat_0000", FEAT ? 5 : 1);
        wait_idle();
        if (FEAT) e = '{4'h0};
        else e = '{4'h0, 4'h0, 4'h0, 4'h0};
        check_stream("s_0000", e);

        send(16'h1000);
        wait_idle();
        e = '{4'h1, 4'h0, 4'h0, 4'h0};
        check_stream("s_1000", e);

        send(16'hE0E0);
        wait_idle();
        e = '{4'hE, 4'h0, 4'hE, 4'h0};
        check_stream("s_e0e0", e);

        // Random traffic checked by the reference every cycle.
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            in        = rand_word();
            in_valid  = ($urandom_range(0, 3) == 0);
            out_ready = ($urandom_range(0, 3) != 0);
            reset     = ($urandom_range(0, 299) == 0);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
